// File: rtl/uart_rx_oversampled.sv
// ============================================================================
// uart_rx_oversampled
//   8-bit UART receiver (8N1, LSB first) running on an OVERSAMPLE x baud clock.
//   The asynchronous serial line passes through a two-flop synchroniser. The
//   start bit is re-checked at its mid-point, which rejects short glitches.
//   Each data bit and the stop bit are sampled at their centres. A received
//   byte is presented on 'out' together with a one-cycle 'done' strobe.
//
// Parameters
//   OVERSAMPLE : clk cycles per bit period (even, >= 4)
//
// Ports
//   clk   in   1  oversample clock
//   rst_n in   1  synchronous active-low reset
//   en    in   1  enable; low behaves as a synchronous reset of FSM and outputs
//   in    in   1  serial rx line (asynchronous, idle high)
//   out   out  8  last received byte, held until the next done
//   busy  out  1  frame reception in progress
//   done  out  1  one-cycle strobe: frame complete, out valid
//   err   out  1  framing error (stop bit sampled low), valid with done
// ============================================================================
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int CW   = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    // Reset and disable have identical effect.
    logic clear;
    assign clear = !rst_n || !en;

    // ------------------------------------------------------------------
    // Two-flop synchroniser. Both flops reset to the idle (high) level so
    // leaving reset never looks like a start edge.
    // ------------------------------------------------------------------
    logic s1_reg;
    logic rx_s_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            s1_reg   <= 1'b1;
            rx_s_reg <= 1'b1;
        end else begin
            s1_reg   <= in;
            rx_s_reg <= s1_reg;
        end
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_t          state_reg,  state_next;
    logic [CW-1:0]   cnt_reg,    cnt_next;
    logic [2:0]      idx_reg,    idx_next;
    logic [7:0]      shreg_reg,  shreg_next;
    logic [7:0]      out_reg,    out_next;
    logic            busy_reg,   busy_next;
    logic            done_reg,   done_next;
    logic            err_reg,    err_next;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shreg_reg <= '0;
            out_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shreg_reg <= shreg_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shreg_next = shreg_reg;
        out_next   = out_reg;
        busy_next  = busy_reg;
        // done and err are strobes: they only live for the cycle they are set
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (!rx_s_reg) begin
                    state_next = START_BIT;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end
            end

            START_BIT: begin
                if (cnt_reg == CNT_HALF) begin
                    // Mid-point of the start bit: still low means a real
                    // frame, high means the low level was only a glitch.
                    if (!rx_s_reg) begin
                        state_next = DATA_BITS;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DATA_BITS: begin
                if (cnt_reg == CNT_LAST) begin
                    // Counter was zeroed at mid start bit, so reaching the
                    // last count lands on the centre of each data bit.
                    cnt_next   = '0;
                    shreg_next = {rx_s_reg, shreg_reg[7:1]};
                    idx_next   = idx_reg + 1'b1;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP_BIT;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            STOP_BIT: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next  = '0;
                    out_next  = shreg_reg;
                    done_next = 1'b1;
                    busy_next = 1'b0;
                    err_next  = !rx_s_reg;
                    // Leaving at mid stop bit gives half a bit of margin to
                    // catch a back-to-back start edge.
                    state_next = rx_s_reg ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            WAIT_IDLE: begin
                // Framing error or break: hold off until the line is idle.
                busy_next = 1'b0;
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign out  = out_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// ============================================================================
// tb_uart_rx_oversampled
//   Self-checking bench for uart_rx_oversampled (OVERSAMPLE = 16).
//   A frame-level model predicts, for each transmitted frame, the cycle of the
//   done strobe, the byte and the error flag; a monitor records every done
//   strobe the DUT actually produces and the two lists are compared.
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int OS   = 16;
    localparam int HALF = OS / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       rx_line = 1'b1;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       err;

    uart_rx_oversampled #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (rx_line),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Posedge counter: after posedge k (and until the next one) cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       ferr;
    } ev_t;

    ev_t ev_q[$];    // observed done strobes
    ev_t exp_q[$];   // predicted done strobes

    int   checks = 0;
    int   errors = 0;
    int   busy_rise = -1;
    int   busy_fall = -1;
    logic busy_prev = 1'b0;

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (done) ev_q.push_back('{cyc, out, err});
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
        $display("check %s observed %0h expected %0h", tag, obs, expv);
    endtask

    // Wait k clock cycles, ending 1 ns after a posedge.
    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmit one full frame; the model predicts done at N+2+HALF+9*OS
    // where N is the posedge that first samples the start bit.
    task automatic send_byte(input logic [7:0] d, input logic stop, output int n);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        n = cyc + 1;
        for (int b = 0; b < 10; b++) begin
            rx_line = bits[b];
            idle(OS);
        end
        exp_q.push_back('{n + 2 + HALF + 9 * OS, d, ~stop});
    endtask

    // Transmit the start bit and the first nb data bits, then release the line.
    task automatic send_partial(input logic [7:0] d, input int nb);
        logic [8:0] bits;
        bits = {d, 1'b0};
        for (int b = 0; b <= nb; b++) begin
            rx_line = bits[b];
            idle(OS);
        end
        rx_line = 1'b1;
    endtask

    task automatic check_events(input string tag);
        chk({tag, " done count"}, 32'(ev_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            chk($sformatf("%s[%0d] done cycle", tag, i), 32'(ev_q[i].at), 32'(exp_q[i].at));
            chk($sformatf("%s[%0d] out", tag, i), 32'(ev_q[i].data), 32'(exp_q[i].data));
            chk($sformatf("%s[%0d] err", tag, i), 32'(ev_q[i].ferr), 32'(exp_q[i].ferr));
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " out"},  32'(out),  32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " err"},  32'(err),  32'h0);
    endtask

    initial begin
        int n;
        int bcnt;
        logic [7:0] d;
        logic       stop;

        @(posedge clk);
        #1;
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle(3);
        chk_cleared("reset");
        rst_n = 1'b1;
        idle(20);

        // ---------------- 1: frame 0xA5 ----------------
        send_byte(8'hA5, 1'b1, n);
        idle(10);
        check_events("t1");
        chk("t1 busy rise", 32'(busy_rise), 32'(n + 2));
        chk("t1 busy fall", 32'(busy_fall), 32'(n + 2 + HALF + 9 * OS));
        chk("t1 out held", 32'(out), 32'hA5);

        // ---------------- 2: glitches of 4 and HALF cycles ----------------
        for (int g = 0; g < 2; g++) begin
            int len;
            len = (g == 0) ? 4 : HALF;
            n = cyc + 1;
            rx_line = 1'b0;
            idle(len);
            rx_line = 1'b1;
            idle(30);
            chk($sformatf("t2 glitch%0d busy rise", len), 32'(busy_rise), 32'(n + 2));
            chk($sformatf("t2 glitch%0d busy width", len), 32'(busy_fall - busy_rise), 32'(HALF));
            chk($sformatf("t2 glitch%0d busy idle", len), 32'(busy), 32'h0);
            check_events($sformatf("t2 glitch%0d", len));
        end

        // ---------------- 3: framing error 0x3C, line held low ----------------
        send_byte(8'h3C, 1'b0, n);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (busy) bcnt++;
        end
        chk("t3 busy while line low", 32'(bcnt), 32'h0);
        check_events("t3");
        rx_line = 1'b1;
        idle(5);
        send_byte(8'h96, 1'b1, n);
        idle(10);
        check_events("t3 recover");

        // ---------------- 4: back-to-back 0x00, 0xFF ----------------
        send_byte(8'h00, 1'b1, n);
        send_byte(8'hFF, 1'b1, n);
        idle(10);
        check_events("t4");

        // ---------------- 5: reset during bit 4 of 0x55 ----------------
        send_partial(8'h55, 4);
        idle(5);
        rst_n = 1'b0;
        idle(1);
        chk_cleared("t5 reset");
        rst_n = 1'b1;
        idle(40);
        check_events("t5 aborted");
        send_byte(8'h81, 1'b1, n);
        idle(10);
        check_events("t5 next");

        // ---------------- 6: en low mid-frame ----------------
        send_partial(8'h33, 3);
        idle(3);
        en = 1'b0;
        idle(2);
        chk_cleared("t6 disabled");
        en = 1'b1;
        idle(30);
        check_events("t6 aborted");
        send_byte(8'h7E, 1'b1, n);
        idle(10);
        check_events("t6 next");

        // ---------------- random frames ----------------
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_byte(d, stop, n);
            if (!stop) begin
                idle($urandom_range(0, 20));
                rx_line = 1'b1;
                idle($urandom_range(2, 30));
            end else begin
                idle($urandom_range(0, 20));
            end
        end
        idle(20);
        check_events("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
